// File: rtl/kfmmc_command.sv
// MMC/SD SPI-mode command sequencer: frames CMDn with CRC7, polls for R1,
// collects optional trailing response bytes and manages card chip-select.
module kfmmc_command #(
    parameter int RESPONSE_POLL_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        command_start,
    input  logic [5:0]  command_index,
    input  logic [31:0] command_argument,
    input  logic [2:0]  response_bytes,
    input  logic        hold_cs,
    output logic        busy,
    output logic        command_done,
    output logic        timeout_error,
    output logic [7:0]  response_r1,
    output logic [31:0] response_data,
    output logic        mmc_cs_n,
    output logic [7:0]  spi_send_data,
    output logic        spi_start,
    input  logic        spi_busy,
    input  logic [7:0]  spi_recv_data
);

    localparam logic [7:0] POLL_LIMIT = 8'(RESPONSE_POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE,
        XFER_START,
        XFER_GUARD,
        XFER_WAIT,
        FRAME,
        POLL,
        RESP,
        TRAIL,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      phase;
    logic [5:0]  index_q;
    logic [31:0] argument_q;
    logic [2:0]  resp_count;
    logic        hold_q;
    logic [2:0]  byte_count;
    logic [7:0]  poll_count;
    logic [6:0]  crc;
    logic        launch;
    logic [7:0]  send_byte;
    logic [7:0]  frame_byte;

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic [7:0] d;
        logic       fb;
        c = crc_in;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[6] ^ d[7];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
            d = {d[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        frame_byte = 8'hFF;
        case (byte_count)
            3'd0:    frame_byte = 8'hFF;
            3'd1:    frame_byte = {2'b01, index_q};
            3'd2:    frame_byte = argument_q[31:24];
            3'd3:    frame_byte = argument_q[23:16];
            3'd4:    frame_byte = argument_q[15:8];
            3'd5:    frame_byte = argument_q[7:0];
            3'd6:    frame_byte = {crc, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Phase states either launch the next byte or hand over to the next phase;
    // received bytes are interpreted in XFER_WAIT according to the saved phase.
    always_comb begin
        state_next   = state;
        launch       = 1'b0;
        send_byte    = 8'hFF;
        spi_start    = 1'b0;
        command_done = 1'b0;
        case (state)
            IDLE: begin
                if (command_start) state_next = FRAME;
            end
            FRAME: begin
                if (byte_count == 3'd7) begin
                    state_next = POLL;
                end else begin
                    launch     = 1'b1;
                    send_byte  = frame_byte;
                    state_next = XFER_START;
                end
            end
            POLL: begin
                if (poll_count == POLL_LIMIT) begin
                    state_next = TRAIL;
                end else begin
                    launch     = 1'b1;
                    state_next = XFER_START;
                end
            end
            RESP: begin
                if (byte_count == resp_count) begin
                    state_next = TRAIL;
                end else begin
                    launch     = 1'b1;
                    state_next = XFER_START;
                end
            end
            TRAIL: begin
                if (hold_q) begin
                    state_next = DONE;
                end else begin
                    launch     = 1'b1;
                    state_next = XFER_START;
                end
            end
            XFER_START: begin
                spi_start  = 1'b1;
                state_next = XFER_GUARD;
            end
            XFER_GUARD: state_next = XFER_WAIT;
            XFER_WAIT: begin
                if (!spi_busy) begin
                    case (phase)
                        FRAME: state_next = FRAME;
                        POLL: begin
                            if (!spi_recv_data[7])
                                state_next = (resp_count != 3'd0) ? RESP : TRAIL;
                            else
                                state_next = POLL;
                        end
                        RESP:    state_next = RESP;
                        TRAIL:   state_next = DONE;
                        default: state_next = IDLE;
                    endcase
                end
            end
            DONE: begin
                command_done = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            timeout_error <= 1'b0;
            response_r1   <= 8'hFF;
            response_data <= '0;
            mmc_cs_n      <= 1'b1;
            spi_send_data <= 8'hFF;
            phase         <= IDLE;
            index_q       <= '0;
            argument_q    <= '0;
            resp_count    <= '0;
            hold_q        <= 1'b0;
            byte_count    <= '0;
            poll_count    <= '0;
            crc           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (command_start) begin
                        index_q       <= command_index;
                        argument_q    <= command_argument;
                        resp_count    <= (response_bytes > 3'd4) ? 3'd4 : response_bytes;
                        hold_q        <= hold_cs;
                        busy          <= 1'b1;
                        timeout_error <= 1'b0;
                        response_r1   <= 8'hFF;
                        response_data <= '0;
                        mmc_cs_n      <= 1'b0;
                        byte_count    <= '0;
                        poll_count    <= '0;
                        crc           <= '0;
                    end
                end
                FRAME: begin
                    if (byte_count == 3'd7) begin
                        byte_count <= '0;
                        poll_count <= '0;
                    end
                end
                POLL: begin
                    if (poll_count == POLL_LIMIT) timeout_error <= 1'b1;
                end
                XFER_WAIT: begin
                    if (!spi_busy) begin
                        case (phase)
                            POLL:    if (!spi_recv_data[7]) response_r1 <= spi_recv_data;
                            RESP:    response_data <= {response_data[23:0], spi_recv_data};
                            TRAIL:   mmc_cs_n <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase

            if (launch) begin
                spi_send_data <= send_byte;
                phase         <= state;
                case (state)
                    FRAME: begin
                        byte_count <= byte_count + 3'd1;
                        // CRC covers bytes 1..5 only; byte 6 reads the finished value
                        if (byte_count >= 3'd1 && byte_count <= 3'd5)
                            crc <= crc7_byte(crc, send_byte);
                    end
                    POLL:    poll_count <= poll_count + 8'd1;
                    RESP:    byte_count <= byte_count + 3'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kfmmc_command.sv
// Scoreboard bench for kfmmc_command: a card/SPI-engine model feeds replies,
// expected bytes and results are queued at issue time and checked by monitors.
module tb_kfmmc_command;

    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        command_start;
    logic [5:0]  command_index;
    logic [31:0] command_argument;
    logic [2:0]  response_bytes;
    logic        hold_cs;
    logic        busy;
    logic        command_done;
    logic        timeout_error;
    logic [7:0]  response_r1;
    logic [31:0] response_data;
    logic        mmc_cs_n;
    logic [7:0]  spi_send_data;
    logic        spi_start;
    logic        spi_busy;
    logic [7:0]  spi_recv_data;

    always #5 clock = ~clock;

    kfmmc_command #(.RESPONSE_POLL_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .command_start(command_start),
        .command_index(command_index),
        .command_argument(command_argument),
        .response_bytes(response_bytes),
        .hold_cs(hold_cs),
        .busy(busy),
        .command_done(command_done),
        .timeout_error(timeout_error),
        .response_r1(response_r1),
        .response_data(response_data),
        .mmc_cs_n(mmc_cs_n),
        .spi_send_data(spi_send_data),
        .spi_start(spi_start),
        .spi_busy(spi_busy),
        .spi_recv_data(spi_recv_data)
    );

    typedef struct {
        logic [7:0]  r1;
        logic [31:0] data;
        logic        tmo;
        logic        cs_n;
    } result_t;

    int checks = 0;
    int fails  = 0;
    int lat    = 3;
    int starts_seen = 0;
    logic [7:0] card_q[$];
    logic [7:0] exp_byte_q[$];
    result_t    exp_res_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Remainder of msg * x^7 divided by x^7+x^3+1, packed with the stop bit.
    function automatic logic [7:0] crc_byte_model(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        return {r[6:0], 1'b1};
    endfunction

    // SPI engine + card model, also checks every byte the DUT launches.
    initial begin
        logic [7:0] reply;
        spi_busy      = 1'b0;
        spi_recv_data = 8'hFF;
        forever begin
            @(negedge clock);
            if (spi_start === 1'b1) begin
                check("start_while_busy", spi_busy, 0);
                check("cs_low_on_start", mmc_cs_n, 0);
                starts_seen++;
                if (exp_byte_q.size() == 0) fail_now("unexpected_byte");
                else check("send_byte", spi_send_data, exp_byte_q.pop_front());
                reply = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
                spi_busy = 1'b1;
                @(negedge clock);
                check("start_pulse_width", spi_start, 0);
                repeat (lat - 1) @(negedge clock);
                spi_busy      = 1'b0;
                spi_recv_data = reply;
            end
        end
    end

    initial begin
        result_t e;
        forever begin
            @(negedge clock);
            if (command_done === 1'b1) begin
                if (exp_res_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_res_q.pop_front();
                    check("response_r1", response_r1, e.r1);
                    check("response_data", response_data, e.data);
                    check("timeout_error", timeout_error, e.tmo);
                    check("cs_n_at_done", mmc_cs_n, e.cs_n);
                    check("busy_at_done", busy, 1);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_res_q.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) fail_now("timeout_waiting_done");
        check("bytes_consumed", exp_byte_q.size(), 0);
    endtask

    // n_ff: non-R1 poll replies before R1; n_ff >= LIMIT models a silent card.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] nresp,
                           input logic hold, input int n_ff, input logic [7:0] r1,
                           input logic [31:0] resp_val, input int crc_lit, input bit wait_done);
        logic [7:0] fb[7];
        result_t    r;
        int         k;
        fb[0] = 8'hFF;
        fb[1] = {2'b01, idx};
        fb[2] = arg[31:24];
        fb[3] = arg[23:16];
        fb[4] = arg[15:8];
        fb[5] = arg[7:0];
        fb[6] = (crc_lit >= 0) ? 8'(crc_lit) : crc_byte_model({fb[1], arg});
        for (int i = 0; i < 7; i++) begin
            exp_byte_q.push_back(fb[i]);
            card_q.push_back(8'($urandom));
        end
        k = (nresp > 3'd4) ? 4 : int'(nresp);
        r.data = 32'h0;
        if (n_ff >= LIMIT) begin
            for (int i = 0; i < LIMIT; i++) begin
                exp_byte_q.push_back(8'hFF);
                card_q.push_back(8'($urandom) | 8'h80);
            end
            r.tmo = 1'b1;
            r.r1  = 8'hFF;
        end else begin
            for (int i = 0; i <= n_ff; i++) exp_byte_q.push_back(8'hFF);
            for (int i = 0; i < n_ff; i++) card_q.push_back(8'($urandom) | 8'h80);
            card_q.push_back(r1 & 8'h7F);
            r.tmo = 1'b0;
            r.r1  = r1 & 8'h7F;
            for (int j = 0; j < k; j++) begin
                exp_byte_q.push_back(8'hFF);
                card_q.push_back(resp_val[8*(k-1-j) +: 8]);
            end
            r.data = (k == 4) ? resp_val : (resp_val & ((32'h1 << (8 * k)) - 32'h1));
        end
        if (!hold) begin
            exp_byte_q.push_back(8'hFF);
            card_q.push_back(8'($urandom));
        end
        r.cs_n = !hold;
        exp_res_q.push_back(r);
        @(negedge clock);
        command_index    = idx;
        command_argument = arg;
        response_bytes   = nresp;
        hold_cs          = hold;
        command_start    = 1'b1;
        @(negedge clock);
        command_start    = 1'b0;
        command_index    = 6'($urandom);
        command_argument = $urandom;
        response_bytes   = 3'($urandom);
        hold_cs          = 1'($urandom);
        if (wait_done) wait_idle(3000);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (starts_seen < target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) fail_now("timeout_waiting_bytes");
    endtask

    initial begin
        int base;
        reset            = 1'b1;
        command_start    = 1'b0;
        command_index    = '0;
        command_argument = '0;
        response_bytes   = '0;
        hold_cs          = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", command_done, 0);
        check("rst_timeout", timeout_error, 0);
        check("rst_r1", response_r1, 8'hFF);
        check("rst_data", response_data, 0);
        check("rst_cs_n", mmc_cs_n, 1);
        check("rst_send", spi_send_data, 8'hFF);
        check("rst_start", spi_start, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_cmd(6'd0, 32'h0, 3'd0, 1'b0, 2, 8'h01, 32'h0, 8'h95, 1'b1);
        run_cmd(6'd8, 32'h000001AA, 3'd4, 1'b0, 0, 8'h01, 32'h000001AA, 8'h87, 1'b1);
        run_cmd(6'd55, 32'h0, 3'd0, 1'b1, 1, 8'h01, 32'h0, 8'h65, 1'b1);
        check("cs_held_after_cmd55", mmc_cs_n, 0);
        run_cmd(6'd41, 32'h40000000, 3'd0, 1'b0, 0, 8'h00, 32'h0, 8'h77, 1'b1);
        run_cmd(6'd17, 32'h00001000, 3'd0, 1'b0, LIMIT, 8'h00, 32'h0, -1, 1'b1);

        // start pulse during the frame must not disturb the running command
        base = starts_seen;
        run_cmd(6'd13, 32'hDEADBEEF, 3'd2, 1'b0, 1, 8'h05, 32'h1234, -1, 1'b0);
        wait_starts(base + 3);
        command_index    = 6'd9;
        command_argument = 32'h55AA55AA;
        command_start    = 1'b1;
        @(negedge clock);
        command_start    = 1'b0;
        wait_idle(3000);
        repeat (20) @(negedge clock);
        check("no_second_cmd", busy, 0);

        // reset during polling
        base = starts_seen;
        run_cmd(6'd1, 32'h0, 3'd0, 1'b0, LIMIT, 8'h00, 32'h0, -1, 1'b0);
        wait_starts(base + 9);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cs_n", mmc_cs_n, 1);
        @(posedge clock);
        #1;
        check("abort_busy_next", busy, 0);
        check("abort_cs_n_next", mmc_cs_n, 1);
        check("abort_start_next", spi_start, 0);
        check("abort_r1_next", response_r1, 8'hFF);
        repeat (lat + 4) @(negedge clock);
        exp_byte_q.delete();
        card_q.delete();
        exp_res_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clock);

        lat = 40;
        run_cmd(6'd8, 32'h000001AA, 3'd4, 1'b0, 1, 8'h01, 32'h000001AA, 8'h87, 1'b1);
        lat = 3;
        run_cmd(6'd8, 32'h000001AA, 3'd4, 1'b0, 1, 8'h01, 32'h000001AA, 8'h87, 1'b1);

        for (int t = 0; t < 25; t++) begin
            lat = $urandom_range(1, 6);
            run_cmd(6'($urandom), $urandom, 3'($urandom), 1'($urandom),
                    $urandom_range(0, LIMIT + 1), 8'($urandom), $urandom, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
